// File: rtl/usxgmii_tx_arbiter.sv
// usxgmii_tx_arbiter: packet-granular two-port round-robin arbiter feeding the USXGMII MAC TX port
module usxgmii_tx_arbiter #(
    parameter int MAX_BEATS = 1200
) (
    input  logic        tx_156_25_clk,
    input  logic        tx_rst,
    input  logic        s0_valid,
    input  logic        s0_startofpacket,
    input  logic        s0_endofpacket,
    input  logic        s0_error,
    input  logic [63:0] s0_data,
    input  logic [2:0]  s0_empty,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic        s1_startofpacket,
    input  logic        s1_endofpacket,
    input  logic        s1_error,
    input  logic [63:0] s1_data,
    input  logic [2:0]  s1_empty,
    output logic        s1_ready,
    output logic        mac_tx_valid,
    output logic        mac_tx_startofpacket,
    output logic        mac_tx_endofpacket,
    output logic        mac_tx_error,
    output logic [63:0] mac_tx_data,
    output logic [2:0]  mac_tx_empty,
    input  logic        mac_tx_ready,
    output logic [1:0]  grant,
    output logic        trunc_pulse,
    output logic        orphan_pulse
);
    typedef enum logic [2:0] {IDLE, GNT0, GNT1, DRAIN0, DRAIN1} state_t;
    state_t      r_state, w_next;
    logic        r_last, r_trunc, r_orphan;
    logic [11:0] r_bcnt;
    logic        w_sel, w_gnt, w_drain, w_v, w_sop, w_eop, w_err, w_wd, w_acc;
    logic        w_c0, w_c1, w_win, w_orph0, w_orph1;
    logic [63:0] w_data;
    logic [2:0]  w_empty;

    assign w_sel   = r_state == GNT1 || r_state == DRAIN1;
    assign w_gnt   = r_state == GNT0 || r_state == GNT1;
    assign w_drain = r_state == DRAIN0 || r_state == DRAIN1;
    assign w_v     = w_sel ? s1_valid : s0_valid;
    assign w_sop   = w_sel ? s1_startofpacket : s0_startofpacket;
    assign w_eop   = w_sel ? s1_endofpacket : s0_endofpacket;
    assign w_err   = w_sel ? s1_error : s0_error;
    assign w_data  = w_sel ? s1_data : s0_data;
    assign w_empty = w_sel ? s1_empty : s0_empty;
    assign w_wd    = w_gnt && r_bcnt == 12'(MAX_BEATS - 1) && !w_eop;
    assign w_acc   = w_gnt && w_v && mac_tx_ready;
    assign w_c0    = s0_valid && s0_startofpacket;
    assign w_c1    = s1_valid && s1_startofpacket;
    assign w_win   = (w_c0 && w_c1) ? !r_last : w_c1;
    assign w_orph0 = r_state == IDLE && s0_valid && !s0_startofpacket;
    assign w_orph1 = r_state == IDLE && s1_valid && !s1_startofpacket;

    // next state and the zero-latency mux; every output is forced low while reset is held
    always_comb begin
        w_next = r_state;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        grant = 2'b00;
        mac_tx_valid = 1'b0;
        mac_tx_startofpacket = 1'b0;
        mac_tx_endofpacket = 1'b0;
        mac_tx_error = 1'b0;
        mac_tx_empty = 3'd0;
        mac_tx_data = 64'd0;
        if (!tx_rst) begin
            s0_ready = w_orph0 || (!w_sel && (w_gnt ? mac_tx_ready : w_drain));
            s1_ready = w_orph1 || (w_sel && (w_gnt ? mac_tx_ready : w_drain));
            grant = (w_gnt || w_drain) ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
            mac_tx_valid = w_gnt && w_v;
            if (w_gnt) begin
                mac_tx_startofpacket = w_sop;
                mac_tx_endofpacket = w_eop || w_wd;
                mac_tx_error = w_err || w_wd;
                mac_tx_empty = w_wd ? 3'd0 : w_empty;
                mac_tx_data = w_data;
            end
            if (r_state == IDLE && (w_c0 || w_c1)) w_next = w_win ? GNT1 : GNT0;
            else if (w_acc && w_eop) w_next = IDLE;
            else if (w_acc && w_wd) w_next = w_sel ? DRAIN1 : DRAIN0;
            else if (w_drain && w_v && w_eop) w_next = IDLE;
        end
    end

    // state, round-robin history, per-packet beat count and registered event pulses
    always_ff @(posedge tx_156_25_clk) begin
        if (tx_rst) begin
            r_state <= IDLE;
            r_last <= 1'b1;
            r_bcnt <= 12'd0;
            r_trunc <= 1'b0;
            r_orphan <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && (w_c0 || w_c1)) r_last <= w_win;
            r_bcnt <= w_gnt ? r_bcnt + 12'(w_acc) : 12'd0;
            r_trunc <= w_acc && w_wd;
            r_orphan <= w_orph0 || w_orph1;
        end
    end

    assign trunc_pulse = r_trunc;
    assign orphan_pulse = r_orphan;
endmodule

// File: tb/tb_usxgmii_tx_arbiter.sv
// tb_usxgmii_tx_arbiter: randomized scoreboard bench for the two-port MAC TX arbiter
module tb_usxgmii_tx_arbiter;
    localparam int MB = 8;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic        err;
        logic [2:0]  empty;
        logic [63:0] data;
        logic        tr;
    } beat_t;

    logic clk = 1'b0, rst = 1'b1;
    logic s0_valid = 1'b0, s0_sop = 1'b0, s0_eop = 1'b0, s0_err = 1'b0, s0_ready;
    logic s1_valid = 1'b0, s1_sop = 1'b0, s1_eop = 1'b0, s1_err = 1'b0, s1_ready;
    logic [63:0] s0_data = 64'd0, s1_data = 64'd0, mac_tx_data;
    logic [2:0] s0_empty = 3'd0, s1_empty = 3'd0, mac_tx_empty;
    logic mac_tx_valid, mac_tx_startofpacket, mac_tx_endofpacket, mac_tx_error;
    logic mac_tx_ready = 1'b0;
    logic [1:0] grant;
    logic trunc_pulse, orphan_pulse;
    logic [76:0] all_out;

    beat_t q0[$], q1[$];
    int ord[$];
    int checks = 0, errors = 0, rdy_mode = 0, orph_seen = 0, trunc_seen = 0, tr_exp = 0;
    bit tp_exp = 0, prev_eop = 0, prev_stall = 0;
    beat_t prev_g;

    usxgmii_tx_arbiter #(.MAX_BEATS(MB)) dut (
        .tx_156_25_clk(clk), .tx_rst(rst),
        .s0_valid(s0_valid), .s0_startofpacket(s0_sop), .s0_endofpacket(s0_eop), .s0_error(s0_err),
        .s0_data(s0_data), .s0_empty(s0_empty), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_startofpacket(s1_sop), .s1_endofpacket(s1_eop), .s1_error(s1_err),
        .s1_data(s1_data), .s1_empty(s1_empty), .s1_ready(s1_ready),
        .mac_tx_valid(mac_tx_valid), .mac_tx_startofpacket(mac_tx_startofpacket),
        .mac_tx_endofpacket(mac_tx_endofpacket), .mac_tx_error(mac_tx_error),
        .mac_tx_data(mac_tx_data), .mac_tx_empty(mac_tx_empty), .mac_tx_ready(mac_tx_ready),
        .grant(grant), .trunc_pulse(trunc_pulse), .orphan_pulse(orphan_pulse)
    );

    assign all_out = {s0_ready, s1_ready, mac_tx_valid, mac_tx_startofpacket, mac_tx_endofpacket,
                      mac_tx_error, mac_tx_empty, mac_tx_data, grant, trunc_pulse, orphan_pulse};

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1);
    end

    function automatic void check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // MAC ready pattern: 0 always ready, 1 alternating, 2 random
    initial forever begin
        @(posedge clk);
        #1;
        mac_tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? !mac_tx_ready : ($urandom % 4 != 0);
    end

    // monitor: pops the expected beat of the granted port on every MAC acceptance
    always @(negedge clk) begin
        beat_t g, b, e;
        int p;
        if (rst) begin
            prev_eop = 0;
            prev_stall = 0;
            tp_exp = 0;
        end else begin
            check("trunc_pulse", trunc_pulse, tp_exp);
            if (orphan_pulse) orph_seen++;
            if (trunc_pulse) trunc_seen++;
            if (prev_eop) check("idle_after_eop", {mac_tx_valid, grant}, 3'b0);
            g = {mac_tx_startofpacket, mac_tx_endofpacket, mac_tx_error, mac_tx_empty, mac_tx_data, 1'b0};
            if (prev_stall) check("stall_hold", {mac_tx_valid, g}, {1'b1, prev_g});
            if (mac_tx_valid) begin
                check("grant_onehot", grant == 2'b01 || grant == 2'b10, 1'b1);
                check("ready_mirror", {s0_ready, s1_ready},
                      grant[1] ? {1'b0, mac_tx_ready} : {mac_tx_ready, 1'b0});
            end
            tp_exp = 0;
            prev_eop = 0;
            if (mac_tx_valid && mac_tx_ready) begin
                p = int'(grant[1]);
                if ((p == 1 ? q1.size() : q0.size()) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got beat %h on port %0d, expected none", g, p);
                end else begin
                    b = p == 1 ? q1.pop_front() : q0.pop_front();
                    e = b;
                    e.tr = 1'b0;
                    check("mac_beat", g, e);
                    tp_exp = b.tr;
                    if (b.sop) ord.push_back(p);
                    prev_eop = mac_tx_endofpacket && !b.tr;
                end
            end
            prev_stall = mac_tx_valid && !mac_tx_ready;
            prev_g = g;
        end
    end

    task automatic drive(input int p, input logic v, input logic sop, input logic eop, input logic err,
                         input logic [2:0] emp, input logic [63:0] d);
        if (p == 0) begin
            s0_valid = v; s0_sop = sop; s0_eop = eop; s0_err = err; s0_empty = emp; s0_data = d;
        end else begin
            s1_valid = v; s1_sop = sop; s1_eop = eop; s1_err = err; s1_empty = emp; s1_data = d;
        end
    endtask

    task automatic wait_acc(input int p, output int n);
        logic a;
        n = 0;
        do begin
            @(negedge clk);
            a = p == 1 ? s1_ready : s0_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!a && n < 300);
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: port %0d ready low for %0d cycles, expected acceptance", p, n);
        end
    endtask

    // reference: a packet reaches the MAC as its first MB beats, the MB-th forced to EOP+error when longer
    task automatic send_pkt(input int p, input int len, input bit gaps, input bit keep, input int emp_eop,
                            output int w_first, output int w_total);
        beat_t bt;
        logic [63:0] d;
        logic err, sop, eop, tr;
        logic [2:0] emp;
        int n;
        w_first = 0;
        w_total = 0;
        for (int k = 0; k < len; k++) begin
            d = {$urandom, $urandom};
            err = ($urandom % 8) == 0;
            emp = 3'($urandom);
            sop = k == 0;
            eop = k == len - 1;
            if (eop && emp_eop >= 0) emp = 3'(emp_eop);
            tr = k == MB - 1 && len > MB;
            if (k < MB) begin
                bt.sop = sop;
                bt.eop = eop | tr;
                bt.err = err | tr;
                bt.empty = tr ? 3'd0 : emp;
                bt.data = d;
                bt.tr = tr;
                if (p == 0) q0.push_back(bt);
                else q1.push_back(bt);
            end
            if (tr) tr_exp++;
            if (gaps) repeat ($urandom % 3) begin
                drive(p, 1'b0, sop, eop, err, emp, d);
                @(posedge clk);
                #1;
            end
            drive(p, 1'b1, sop, eop, err, emp, d);
            wait_acc(p, n);
            if (k == 0) w_first = n;
            w_total += n;
        end
        if (!keep) drive(p, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
    endtask

    initial begin
        int wf, wt, wf1, wt1, base, n;
        beat_t bt;
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 64'hdead);
        drive(1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 64'hbeef);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_out, 77'd0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", all_out, 77'd0);
        @(posedge clk);
        #1;

        rdy_mode = 0;
        ord.delete();
        fork
            begin
                send_pkt(0, $urandom_range(1, 4), 0, 1, -1, wf, wt);
                send_pkt(0, $urandom_range(1, 4), 0, 0, -1, wf, wt);
            end
            begin
                send_pkt(1, $urandom_range(1, 4), 0, 1, -1, wf1, wt1);
                send_pkt(1, $urandom_range(1, 4), 0, 0, -1, wf1, wt1);
            end
        join
        @(negedge clk);
        check("contention_count", ord.size(), 4);
        if (ord.size() == 4)
            check("contention_order", {ord[0][0], ord[1][0], ord[2][0], ord[3][0]}, 4'b0101);
        @(posedge clk);
        #1;

        send_pkt(0, 4, 0, 0, 3, wf, wt);
        check("grant_latency", wf, 2);
        check("single_no_gaps", wt, 5);

        rdy_mode = 1;
        base = trunc_seen;
        send_pkt(1, MB, 0, 0, -1, wf, wt);
        @(negedge clk);
        check("max_len_no_trunc", trunc_seen - base, 0);
        rdy_mode = 0;
        @(posedge clk);
        #1;

        base = trunc_seen;
        send_pkt(0, MB + 3, 0, 0, -1, wf, wt);
        check("drain_no_stall", wt, MB + 4);
        @(negedge clk);
        check("idle_after_drain", grant, 2'b00);
        @(negedge clk);
        check("oversize_trunc_once", trunc_seen - base, 1);
        @(posedge clk);
        #1;

        base = orph_seen;
        repeat (2) begin
            drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 3'($urandom), {$urandom, $urandom});
            wait_acc(1, n);
        end
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        repeat (2) @(negedge clk);
        check("orphan_pulses", orph_seen - base, 2);
        @(posedge clk);
        #1;

        rdy_mode = 2;
        fork
            for (int i = 0; i < 30; i++) send_pkt(0, $urandom_range(1, MB + 4), 1, 0, -1, wf, wt);
            for (int j = 0; j < 30; j++) send_pkt(1, $urandom_range(1, MB + 4), 1, 0, -1, wf1, wt1);
        join
        @(negedge clk);
        check("random_drained", q0.size() + q1.size(), 0);
        @(posedge clk);
        #1;

        rdy_mode = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            bt = {k == 0, 1'b0, 1'b0, 3'($urandom), {$urandom, $urandom}, 1'b0};
            q0.push_back(bt);
            drive(0, 1'b1, bt.sop, 1'b0, 1'b0, bt.empty, bt.data);
            wait_acc(0, n);
        end
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 64'h3333);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midpkt_reset_outputs", all_out, 77'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        ord.delete();
        fork
            send_pkt(1, 3, 0, 0, -1, wf, wt);
            begin
                @(negedge clk);
                check("post_reset_idle", all_out, 77'd0);
            end
        join
        check("post_reset_latency", wf, 2);
        @(negedge clk);
        check("post_reset_s1_first", ord.size() == 1 && ord[0] == 1, 1'b1);
        check("queues_empty", q0.size() + q1.size(), 0);
        check("trunc_total", trunc_seen, tr_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/usxgmii_tx_arbiter.md
# usxgmii_tx_arbiter

Packet-granular two-port round-robin arbiter feeding the 64-bit Avalon-ST TX input of the USXGMII MAC. Two transmit sources (e.g. a CPU path and a hardware datapath) share the single MAC TX port without interleaving packets. The block runs in the MAC's 156.25 MHz TX domain. It adds two protections:

- **Oversize watchdog:** truncates any packet that exceeds a configurable beat limit.
- **Orphan discard:** discards beats that arrive outside a packet.

## Interface
Parameters:
- `MAX_BEATS`, default 1200: maximum beats per packet; the beat numbered `MAX_BEATS` is forced to end-of-packet. Legal range 2..4095.

Ports:
- `tx_156_25_clk` in 1: sole clock.
- `tx_rst` in 1: reset; **synchronous, active-high**.
- `s0_valid`, `s0_startofpacket`, `s0_endofpacket`, `s0_error` in 1 each: source 0 Avalon-ST control.
- `s0_data` in 64: source 0 data.
- `s0_empty` in 3: source 0 empty bytes on the EOP beat.
- `s0_ready` out 1: source 0 ready.
- `s1_*` (same set as `s0_*`): source 1.
- `mac_tx_valid`, `mac_tx_startofpacket`, `mac_tx_endofpacket`, `mac_tx_error` out 1 each: to MAC `avalon_st_tx`.
- `mac_tx_data` out 64, `mac_tx_empty` out 3: to MAC.
- `mac_tx_ready` in 1: from MAC.
- `grant` out 2: one-hot current owner; `2'b00` when none.
- `trunc_pulse` out 1: one-cycle pulse when a packet is truncated.
- `orphan_pulse` out 1: one-cycle pulse per discarded orphan beat.

## Operation
Beat acceptance:
- A beat on source *i* is accepted when `si_valid && si_ready`.
- A MAC beat is accepted when `mac_tx_valid && mac_tx_ready`.

State machine (registered): IDLE, GNT0, GNT1, DRAIN0, DRAIN1.

IDLE:
- All `si_ready`=0, except for orphan discard (below).
- `mac_tx_valid`=0.
- Candidate *i* means `si_valid && si_startofpacket`.
- If both ports are candidates, the port not served last wins. `last` resets to 1, so port 0 wins first.
- Next state is GNTi; `last`←i is updated at grant.
- Orphan discard: if `si_valid && !si_startofpacket` in IDLE, `si_ready`=1, the beat is dropped and `orphan_pulse`=1. Both ports may discard in the same cycle; `orphan_pulse` is then asserted for a single cycle.

GNTi:
- Datapath is a combinational mux from source i to `mac_tx_*`: `mac_tx_valid`=`si_valid`, `si_ready`=`mac_tx_ready`. The other port's ready is 0.
- Beat counter `bcnt` (12 b) clears on grant and increments per accepted beat.
- On an accepted beat with `si_endofpacket`: next state IDLE.
- Watchdog: if `bcnt == MAX_BEATS-1` and the current beat lacks EOP, the outputs are overridden to `mac_tx_endofpacket`=1, `mac_tx_error`=1, `mac_tx_empty`=0. On acceptance: `trunc_pulse`=1 and next state DRAINi.
- A SOP arriving mid-packet (no EOP seen) is forwarded unchanged. The MAC flags the error.

DRAINi:
- `si_ready`=1, `mac_tx_valid`=0, and beats are discarded.
- On an accepted beat with EOP: next state IDLE.

`grant` reflects GNTi/DRAINi. It is 0 in IDLE.

## Timing
- Reset values: state IDLE, `last`=1, `bcnt`=0, and every output 0 (`si_ready`, `mac_tx_*`, `grant`, pulses). Reset mid-packet abandons the packet with no EOP to the MAC; the next packet starts after reset.
- Grant latency: SOP presented in IDLE at cycle N → GNT at N+1. The first beat can be accepted at N+1.
- One mandatory IDLE cycle after every EOP. For back-to-back single-beat packets, throughput is ≥1 packet per 2 cycles.
- Data/ready path through the mux has zero latency. `mac_tx_*` is stable while `mac_tx_valid && !mac_tx_ready`, because the source holds per Avalon-ST.
- Pulses are registered: asserted in the cycle after the triggering acceptance, for exactly one cycle.
- `bcnt` never wraps, because the watchdog fires first.

## Test plan
- **Single packet:** s0 sends a 4-beat packet with `empty`=3 and `mac_tx_ready`=1. Expect the MAC to see 4 beats starting cycle N+1, EOP beat `empty`=3, `grant`=01 then 00, and no gaps inside the packet.
- **Contention:** both ports present SOP in the same cycle after reset. Expect order s0, s1, s0, s1 across 4 packets, with one IDLE cycle between each and no interleaved beats.
- **Backpressure:** `mac_tx_ready` toggles 1,0,1,0 during an 8-beat s1 packet. Expect `s1_ready` to mirror `mac_tx_ready`, all 8 beats delivered in order, and data held while stalled.
- **Oversize:** `MAX_BEATS`=4, s0 sends a 7-beat packet. Expect the MAC 4th beat to carry EOP=1, error=1, empty=0, and `trunc_pulse` once. s0 beats 5–7 are consumed with `mac_tx_valid`=0, then the state returns to IDLE.
- **Orphans:** s1 presents 2 valid non-SOP beats in IDLE. Expect `s1_ready`=1, 2 `orphan_pulse` cycles, and no MAC output.
- **Reset mid-packet:** assert `tx_rst` on beat 3 of a 6-beat s0 packet. Expect all outputs 0 the next cycle, and a fresh SOP on s1 granted first (`last`=1 → s0 wins only if it also presents SOP).
